// File: rtl/seg7_scan_display_if.sv
// Display-side bundle for seg7_scan_display: value/load request, busy status,
// per-digit masks, and the active-low anode/cathode/dp pins.
// master = application side (drives value/masks), slave = the display driver.
interface seg7_scan_display_if #(
    parameter int N_DIGITS = 8,
    parameter int VAL_W    = 27
);
    logic [VAL_W-1:0]    value;       // binary value to display
    logic                load;        // capture strobe, honoured only when busy=0
    logic                busy;        // conversion in progress
    logic [N_DIGITS-1:0] dp_mask;     // 1 = light decimal point of digit i
    logic [N_DIGITS-1:0] blink_mask;  // 1 = digit i blinks while blink_ena=1
    logic                blink_ena;   // global blink enable
    logic [N_DIGITS-1:0] anode;       // active-low digit select
    logic [6:0]          cathode;     // active-low segments {g,f,e,d,c,b,a}
    logic                dp;          // active-low decimal point

    modport master (
        output value, load, dp_mask, blink_mask, blink_ena,
        input  busy, anode, cathode, dp
    );

    modport slave (
        input  value, load, dp_mask, blink_mask, blink_ena,
        output busy, anode, cathode, dp
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment driver: sequential binary->BCD (shift-add-3) plus digit scan.
// Latency: load -> display register VAL_W+1 cycles; pins update on each scan tick.
// Backpressure: load is ignored while busy=1 (value not re-sampled).
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   bus   - slave side of seg7_scan_display_if (value/load/busy, masks, anode/cathode/dp)
module seg7_scan_display #(
    parameter int N_DIGITS  = 8,
    parameter int VAL_W     = 27,
    parameter int SCAN_DIV  = 125000,
    parameter int BLINK_DIV = 400,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_display_if.slave bus
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int PW    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW    = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
    localparam int SW    = $clog2(VAL_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [VAL_W-1:0] r_bin;        // binary shift register, MSB shifted out first
    logic [BCD_W-1:0] r_bcd_work;   // BCD accumulator during conversion
    logic [BCD_W-1:0] r_bcd_disp;   // BCD shown on the display, updated atomically
    logic [SW-1:0]    r_step;       // shift steps done so far
    logic [BCD_W-1:0] w_bcd_adj;
    logic [BCD_W-1:0] w_bcd_step;
    logic             w_copy;

    // After VAL_W shifts the accumulator is complete; one more CONV cycle
    // copies it into the display register, so busy lasts VAL_W+1 cycles.
    assign w_copy = (r_step == SW'(VAL_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.load) w_state_nxt = ST_CONV;
            ST_CONV: if (w_copy)   w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy = (r_state == ST_CONV);

    // Add-3 correction on every digit >= 5 before the shift. Digits above
    // N_DIGITS are simply never stored: lower digits never depend on higher
    // ones, so the result is the value modulo 10^N_DIGITS.
    always_comb begin
        w_bcd_adj = r_bcd_work;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (r_bcd_work[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd_work[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_step = {w_bcd_adj[BCD_W-2:0], r_bin[VAL_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= '0;
            r_bcd_work <= '0;
            r_bcd_disp <= '0;
            r_step     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_bin      <= bus.value;
                        r_bcd_work <= '0;
                        r_step     <= '0;
                    end
                end
                ST_CONV: begin
                    if (w_copy) begin
                        r_bcd_disp <= r_bcd_work;
                    end else begin
                        r_bcd_work <= w_bcd_step;
                        r_bin      <= r_bin << 1;
                        r_step     <= r_step + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Blink phase: counts scan ticks; r_blink_off=1 is the dark half-period
    // ------------------------------------------------------------------
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (!bus.blink_ena) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-slot selection, leading-zero detection and segment decode
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] w_lz_blank;   // digit d and everything above it is zero
    logic                w_nz_acc;
    logic [3:0]          w_digit;
    logic                w_dp_on;
    logic                w_blink_sel;
    logic                w_lz_sel;
    logic [6:0]          w_seg;
    logic                w_hide;

    // Scan from the top digit down, remembering whether a non-zero digit
    // has been seen; digit 0 is never blanked.
    always_comb begin
        w_lz_blank = '0;
        w_nz_acc   = 1'b0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            w_nz_acc      = w_nz_acc | (r_bcd_disp[4*d +: 4] != 4'd0);
            w_lz_blank[d] = ~w_nz_acc & (d != 0);
        end
    end

    always_comb begin
        w_digit     = 4'd0;
        w_dp_on     = 1'b0;
        w_blink_sel = 1'b0;
        w_lz_sel    = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (r_idx == IW'(d)) begin
                w_digit     = r_bcd_disp[4*d +: 4];
                w_dp_on     = bus.dp_mask[d];
                w_blink_sel = bus.blink_mask[d];
                w_lz_sel    = w_lz_blank[d];
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;   // 10..15 cannot occur; show nothing
        endcase
    endfunction

    always_comb begin
        w_seg = seg_decode(w_digit);
        if (LZ_BLANK && w_lz_sel) begin
            w_seg = SEG_BLANK;
        end
    end

    // Blinking hides both segments and dp; leading-zero blanking leaves dp alone.
    assign w_hide = r_blink_off & w_blink_sel;

    // ------------------------------------------------------------------
    // Registered pin outputs, refreshed only on a scan tick. A display
    // register update on the same edge is seen from the next tick onward.
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] r_anode;
    logic [6:0]          r_cathode;
    logic                r_dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode   <= '1;
            r_cathode <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else if (w_tick) begin
            r_anode   <= ~(N_DIGITS'(1) << r_idx);
            r_cathode <= w_hide ? SEG_BLANK : w_seg;
            r_dp      <= w_hide ? 1'b1 : ~w_dp_on;
        end
    end

    assign bus.anode   = r_anode;
    assign bus.cathode = r_cathode;
    assign bus.dp      = r_dp;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: random and directed loads, expected slots pushed
// to a queue from a decimal-arithmetic model, a monitor pops and compares per tick.
// Small SCAN_DIV/BLINK_DIV keep the run short.
module tb_seg7_scan_display;
    localparam int N  = 8;
    localparam int W  = 27;
    localparam int SD = 4;
    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_display_if #(.N_DIGITS(N), .VAL_W(W)) u_if ();

    seg7_scan_display #(
        .N_DIGITS (N),
        .VAL_W    (W),
        .SCAN_DIV (SD),
        .BLINK_DIV(BD),
        .LZ_BLANK (1'b1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    typedef struct {
        logic [7:0] anode;
        logic [6:0] cathode;
        logic       dp;
        int         slot;
    } slot_t;

    slot_t      exp_q[$];
    slot_t      mon_e;
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic [7:0] prev_anode = 8'hFF;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected pins for one slot, from decimal arithmetic on the value.
    function automatic slot_t model_slot(input longint val, input int s, input logic [7:0] dpm,
                                         input logic [7:0] bm, input bit off);
        slot_t  e;
        longint v;
        longint p;
        v = val % 64'd100000000;
        p = 1;
        for (int i = 0; i < s; i++) p = p * 10;
        e.slot     = s;
        e.anode    = 8'hFF;
        e.anode[s] = 1'b0;
        if (s > 0 && v < p) e.cathode = 7'h7F;
        else                e.cathode = seg_of(int'((v / p) % 10));
        e.dp = ~dpm[s];
        if (off && bm[s]) begin
            e.cathode = 7'h7F;
            e.dp      = 1'b1;
        end
        return e;
    endfunction

    task automatic push_frame(input longint val, input logic [7:0] dpm);
        for (int s = 0; s < N; s++) exp_q.push_back(model_slot(val, s, dpm, 8'h00, 1'b0));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every anode change is a scan tick; pop when it matches the head.
    always @(negedge clk) begin
        if (u_if.anode !== prev_anode) begin
            prev_anode = u_if.anode;
            if (!rst && exp_q.size() > 0 && u_if.anode === exp_q[0].anode) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if (u_if.cathode !== mon_e.cathode || u_if.dp !== mon_e.dp) begin
                    n_fail++;
                    $display("FAIL slot%0d: cathode=%b dp=%b expected cathode=%b dp=%b",
                             mon_e.slot, u_if.cathode, u_if.dp, mon_e.cathode, mon_e.dp);
                end
            end
        end
    end

    task automatic do_load(input logic [W-1:0] v);
        @(negedge clk);
        u_if.value = v;
        u_if.load  = 1'b1;
        @(negedge clk);
        u_if.load  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int req_len);
        int c;
        c = 0;
        while (u_if.busy === 1'b1 && c < 200) begin
            c++;
            @(negedge clk);
        end
        check(name, c, req_len);
    endtask

    task automatic frame_sync();
        int c;
        c = 0;
        while (u_if.anode !== 8'h7F && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (c >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_sync: anode=%h expected 7f within 200 cycles", u_if.anode);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d slots unseen expected 0 (next anode %h)",
                     exp_q.size(), exp_q[0].anode);
            exp_q.delete();
        end
    endtask

    task automatic show_value(input string name, input longint v, input logic [7:0] dpm);
        do_load(v[W-1:0]);
        wait_idle(name, W + 1);
        frame_sync();
        u_if.dp_mask = dpm;
        push_frame(v, dpm);
        drain();
    endtask

    initial begin
        longint v;
        logic [7:0] dpm;

        rst             = 1'b1;
        u_if.value      = '0;
        u_if.load       = 1'b0;
        u_if.dp_mask    = '0;
        u_if.blink_mask = '0;
        u_if.blink_ena  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_anode",   u_if.anode,   8'hFF);
        check("rst_cathode", u_if.cathode, 7'h7F);
        check("rst_dp",      u_if.dp,      1'b1);
        check("rst_busy",    u_if.busy,    1'b0);
        rst = 1'b0;

        // First tick lands on the SCAN_DIV-th edge after release, digit 0
        repeat (3) @(posedge clk);
        #1 check("pre_tick_anode", u_if.anode, 8'hFF);
        @(posedge clk);
        #1;
        check("tick1_anode",   u_if.anode,   8'hFE);
        check("tick1_cathode", u_if.cathode, 7'b1000000);
        check("tick1_dp",      u_if.dp,      1'b1);

        // Directed values
        show_value("busy_12345678",  64'd12345678,  8'h00);
        show_value("busy_305",       64'd305,       8'h00);
        show_value("busy_134217727", 64'd134217727, 8'h04);
        show_value("busy_zero",      64'd0,         8'h81);

        // Random values, scaled down randomly to exercise leading-zero blanking
        for (int i = 0; i < 8; i++) begin
            v   = longint'($urandom_range(0, 134217727) >> $urandom_range(0, 26));
            dpm = 8'($urandom);
            show_value("busy_rand", v, dpm);
        end

        // Blink: slot 2 blinks with 16-tick half periods (2 frames each)
        show_value("busy_blink", 64'd12345678, 8'h04);
        frame_sync();
        u_if.blink_mask = 8'h04;
        u_if.blink_ena  = 1'b1;
        for (int f = 0; f < 6; f++)
            for (int s = 0; s < N; s++)
                exp_q.push_back(model_slot(64'd12345678, s, 8'h04, 8'h04,
                                           (((8 * f + s) / BD) % 2) == 1));
        drain();
        frame_sync();
        u_if.blink_ena = 1'b0;
        for (int s = 0; s < N; s++)
            exp_q.push_back(model_slot(64'd12345678, s, 8'h04, 8'h04, 1'b0));
        drain();
        u_if.blink_mask = 8'h00;
        u_if.dp_mask    = 8'h00;

        // Load while busy is ignored
        do_load(27'd4321);
        repeat (5) @(negedge clk);
        u_if.value = 27'd999;
        u_if.load  = 1'b1;
        @(negedge clk);
        u_if.load  = 1'b0;
        wait_idle("busy_ignored_load", W + 1 - 6);
        frame_sync();
        push_frame(64'd4321, 8'h00);
        drain();

        // Reset mid-conversion aborts it and clears the display
        do_load(27'd7777777);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",  u_if.busy,  1'b0);
        check("midrst_anode", u_if.anode, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        frame_sync();
        push_frame(64'd0, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
